// File: rtl/synth_pkg.sv
// Shared constants and FSM encoding for the SPI command receiver and dds.
package synth_pkg;

  localparam int unsigned NUM_VOICES = 8;
  localparam int unsigned FRAME_BITS = 48;
  localparam logic [7:0]  OPC_SET_TW = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for one asynchronous input, with rise/fall pulses taken from the
// synchronized level.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise = o_sync & ~r_prev;
  assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/spi_cmd_rx.sv
// SPI mode-0 slave that receives per-voice tuning commands, validates each frame and hands
// it to dds as a one-cycle strobe; a status byte is returned on MISO at the start of a frame.
module spi_cmd_rx
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES  = synth_pkg::NUM_VOICES,
  parameter int unsigned VI_WIDTH    = 8,
  parameter int unsigned TW_WIDTH    = 32,
  parameter logic [7:0]  OPC_SET_TW  = synth_pkg::OPC_SET_TW,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_sclk,
  input  logic                i_cs_n,
  input  logic                i_mosi,
  output logic                o_miso,
  output logic                o_SPI_flag,
  output logic [VI_WIDTH-1:0] o_SPI_voice_index,
  output logic [TW_WIDTH-1:0] o_SPI_tuning_code,
  output logic                o_frame_err
);

  localparam int unsigned FrameBits = 8 + VI_WIDTH + TW_WIDTH;

  logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
  logic w_cs_n_sync, w_cs_rise, w_cs_fall;
  logic w_mosi_sync, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_async   (i_sclk),
    .o_sync    (w_sclk_sync),
    .o_rise    (w_sclk_rise),
    .o_fall    (w_sclk_fall)
  );

  // CS idles high, so its synchronizer resets high to avoid a false edge out of reset.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_async   (i_cs_n),
    .o_sync    (w_cs_n_sync),
    .o_rise    (w_cs_rise),
    .o_fall    (w_cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_async   (i_mosi),
    .o_sync    (w_mosi_sync),
    .o_rise    (w_mosi_rise),
    .o_fall    (w_mosi_fall)
  );

  assign w_unused = ^{w_sclk_sync, w_mosi_rise, w_mosi_fall};

  spi_state_e             r_state;
  logic [FrameBits-1:0]   r_shift;
  logic [5:0]             r_bit_cnt;
  logic [7:0]             r_miso_sr;
  logic                   r_pending;
  logic [5:0]             r_good_cnt;
  logic                   r_overrun;
  logic                   r_frame_err;
  logic                   r_commit;
  logic                   r_flag;
  logic [VI_WIDTH-1:0]    r_voice;
  logic [TW_WIDTH-1:0]    r_tw;

  logic [7:0]             w_opcode;
  logic [VI_WIDTH-1:0]    w_voice;
  logic [TW_WIDTH-1:0]    w_tw;
  logic                   w_frame_ok;
  logic [7:0]             w_status;

  assign w_opcode   = r_shift[TW_WIDTH+VI_WIDTH +: 8];
  assign w_voice    = r_shift[TW_WIDTH +: VI_WIDTH];
  assign w_tw       = r_shift[TW_WIDTH-1:0];
  assign w_frame_ok = (r_bit_cnt == 6'(FrameBits)) && (w_opcode == OPC_SET_TW)
                      && (32'(w_voice) < NUM_VOICES);
  assign w_status   = {r_frame_err, r_overrun, r_good_cnt};

  // Status counters update in CHECK so a frame starting right after sees fresh values;
  // the data outputs follow one cycle later.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_miso_sr   <= '0;
      r_pending   <= 1'b0;
      r_good_cnt  <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_commit    <= 1'b0;
      r_flag      <= 1'b0;
      r_voice     <= '0;
      r_tw        <= '0;
    end else begin
      r_commit <= 1'b0;
      r_flag   <= 1'b0;
      if (r_commit) begin
        r_flag  <= 1'b1;
        r_voice <= w_voice;
        r_tw    <= w_tw;
      end
      case (r_state)
        IDLE: begin
          if (w_cs_fall || r_pending) begin
            r_state   <= SHIFT;
            r_bit_cnt <= '0;
            r_miso_sr <= w_status;
            r_pending <= 1'b0;
          end
        end
        SHIFT: begin
          if (w_cs_rise) begin
            r_state <= CHECK;
          end else begin
            if (w_sclk_rise) begin
              r_shift <= {r_shift[FrameBits-2:0], w_mosi_sync};
              if (r_bit_cnt != 6'd63) r_bit_cnt <= r_bit_cnt + 6'd1;
            end
            if (w_sclk_fall) r_miso_sr <= {r_miso_sr[6:0], 1'b0};
          end
        end
        CHECK: begin
          r_state   <= IDLE;
          r_miso_sr <= '0;
          if (w_cs_fall) r_pending <= 1'b1;
          if (r_bit_cnt != 6'd0) begin
            if (w_frame_ok) begin
              r_commit   <= 1'b1;
              r_good_cnt <= r_good_cnt + 6'd1;
            end else begin
              r_frame_err <= 1'b1;
              if (r_bit_cnt > 6'(FrameBits)) r_overrun <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_miso            = r_miso_sr[7] & ~w_cs_n_sync;
  assign o_SPI_flag        = r_flag;
  assign o_SPI_voice_index = r_voice;
  assign o_SPI_tuning_code = r_tw;
  assign o_frame_err       = r_frame_err;

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Scoreboard bench for spi_cmd_rx: directed SPI frames push expected commands, a monitor
// pops and compares on every o_SPI_flag pulse; MISO status bytes are checked per frame.
module tb_spi_cmd_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic        flag;
  logic [7:0]  voice;
  logic [31:0] tw;
  logic        ferr;

  spi_cmd_rx u_dut (
    .i_clk             (clk),
    .i_reset_n         (rst_n),
    .i_sclk            (sclk),
    .i_cs_n            (cs_n),
    .i_mosi            (mosi),
    .o_miso            (miso),
    .o_SPI_flag        (flag),
    .o_SPI_voice_index (voice),
    .o_SPI_tuning_code (tw),
    .o_frame_err       (ferr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  v;
    logic [31:0] t;
  } cmd_t;

  cmd_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        m_err;
  logic        m_ovr;
  logic [5:0]  m_good;
  logic [7:0]  last_v;
  logic [31:0] last_tw;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    cmd_t e;
    if (rst_n === 1'b1 && flag === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got voice 0x%0h tw 0x%0h, expected no pulse",
                 voice, tw);
      end else begin
        e = exp_q.pop_front();
        check("pulse_voice", 64'(voice), 64'(e.v));
        check("pulse_tuning", 64'(tw), 64'(e.t));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cs_n  = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    m_err = 1'b0;
    m_ovr = 1'b0;
    m_good = '0;
    last_v  = '0;
    last_tw = '0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_frame_err"}, 64'(ferr), 64'(m_err));
    check({tag, "_voice"}, 64'(voice), 64'(last_v));
    check({tag, "_tuning"}, 64'(tw), 64'(last_tw));
  endtask

  // abort_at >= 0 resets the DUT mid-frame after that many bits.
  task automatic send_frame(input logic [63:0] data, input int nbits, input int gap,
                            input int abort_at);
    logic [7:0] mb;
    logic [7:0] exp_status;
    cmd_t       c;
    mb = '0;
    exp_status = {m_err, m_ovr, m_good};
    cs_n = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_at) begin
        do_reset();
        return;
      end
      mosi = data[nbits-1-i];
      tick(4);
      if (i < 8) mb[7-i] = miso;
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    tick(4);
    cs_n = 1'b1;
    if (nbits >= 8) check("miso_status", 64'(mb), 64'(exp_status));
    if (nbits == 48 && data[47:40] == 8'h01 && data[39:32] < 8'd8) begin
      c.v = data[39:32];
      c.t = data[31:0];
      exp_q.push_back(c);
      m_good  = m_good + 6'd1;
      last_v  = data[39:32];
      last_tw = data[31:0];
    end else if (nbits != 0) begin
      m_err = 1'b1;
      if (nbits > 48) m_ovr = 1'b1;
    end
    tick(gap);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    check("reset_flag", 64'(flag), 64'd0);
    check("reset_miso", 64'(miso), 64'd0);
    check_state("reset");

    send_frame(64'h01_05_000F4240, 48, 10, -1);
    check_state("good1");
    check("good1_tuning_const", 64'(tw), 64'd1000000);
    send_frame(64'h01_00_12345678, 48, 10, -1);
    send_frame(64'h01_07_DEADBEEF, 48, 10, -1);

    // Status on this frame must read 8'b0000_0011 (three good frames so far).
    send_frame(64'h02_03_00000010, 48, 10, -1);
    check_state("bad_opcode");
    check("bad_opcode_err_const", 64'(ferr), 64'd1);
    send_frame(64'h01_02_00000100, 48, 10, -1);
    check_state("err_sticky");

    send_frame(64'h01_08_00000001, 48, 10, -1);
    check_state("voice8");
    send_frame(64'h01_04_0000AAAA >> 1, 47, 10, -1);
    check_state("short47");
    send_frame(64'h02_09_00000155, 49, 10, -1);
    check_state("long49");
    send_frame(64'h0, 0, 10, -1);
    check_state("cs_glitch");

    send_frame(64'h01_01_11111111, 48, 2, -1);
    send_frame(64'h01_03_33333333, 48, 10, -1);
    check_state("back_to_back");

    send_frame(64'h01_04_44444444, 48, 10, 20);
    check("midreset_flag", 64'(flag), 64'd0);
    check_state("midreset");
    send_frame(64'h01_06_CAFEF00D, 48, 10, -1);
    check_state("after_midreset");

    do_reset();
    for (int i = 0; i < 65; i++) begin
      send_frame({16'h0, 8'h01, 8'(i % 8), 32'(i * 3 + 1)}, 48, 4, -1);
    end
    tick(10);
    check("wrap_model_cnt", 64'(m_good), 64'd1);
    send_frame(64'h01_00_00000042, 48, 10, -1);
    check_state("final");

    tick(20);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
